// File: rtl/x_stage_md_sched_if.sv
// ============================================================================
// Module      : x_stage_md_sched_if
// Description : Bundle of the mult/div handshake and pipe-register control
//               signals between the X-stage scheduler and the dual-issue
//               pipeline. The master modport is the scheduler side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface x_stage_md_sched_if #(
    parameter int STALL_CNT_W = 16
);
    // Requests and unit handshake
    logic                   md_req_top;
    logic                   md_req_bot;
    logic                   md_ready;
    logic                   ld_use_hazard;
    logic                   br_taken;
    // Mult/div unit control
    logic                   md_start;
    logic                   md_sel;
    logic                   md_cap_top;
    logic                   md_cap_bot;
    // Pipe register control
    logic                   fd_we;
    logic                   dx_we;
    logic                   dx_nop;
    logic                   xm_we;
    logic                   xm_nop;
    logic                   fd_flush;
    logic                   dx_flush;
    // Status
    logic [STALL_CNT_W-1:0] stall_cycles;
    logic                   md_timeout;

    modport master (
        input  md_req_top, md_req_bot, md_ready, ld_use_hazard, br_taken,
        output md_start, md_sel, md_cap_top, md_cap_bot,
        output fd_we, dx_we, dx_nop, xm_we, xm_nop, fd_flush, dx_flush,
        output stall_cycles, md_timeout
    );

    modport slave (
        output md_req_top, md_req_bot, md_ready, ld_use_hazard, br_taken,
        input  md_start, md_sel, md_cap_top, md_cap_bot,
        input  fd_we, dx_we, dx_nop, xm_we, xm_nop, fd_flush, dx_flush,
        input  stall_cycles, md_timeout
    );
endinterface

`default_nettype wire

// File: rtl/x_stage_md_sched.sv
// ============================================================================
// Module      : x_stage_md_sched
// Description : Stall/flush controller for the dual-issue pipeline and
//               scheduler of the shared mult/div unit. Serialises top-then-bot
//               ops, holds X until both results are captured, counts stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module x_stage_md_sched #(
    parameter int MD_MAX_CYCLES = 40,
    parameter int STALL_CNT_W   = 16
) (
    input  wire logic               clk,
    input  wire logic               reset,   // asynchronous, active-low
    x_stage_md_sched_if.master      bus
);

    localparam int c_WAIT_W = $clog2(MD_MAX_CYCLES + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX  = c_WAIT_W'(MD_MAX_CYCLES);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MD_MAX_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_TOP = 2'd1,
        WAIT_BOT = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_WAIT_W-1:0]    r_wait_cnt;
    logic                   r_timeout;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic w_md_start;
    logic w_md_sel;
    logic w_cap_top;
    logic w_cap_bot;
    logic w_x_stall;
    logic w_in_wait;
    logic w_stall_evt;

    // Scheduler next-state and unit-control decode (Mealy, same-cycle)
    always_comb begin
        w_state_nxt = r_state;
        w_md_start  = 1'b0;
        w_md_sel    = 1'b0;
        w_cap_top   = 1'b0;
        w_cap_bot   = 1'b0;
        w_x_stall   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.md_req_top) begin
                    w_md_start  = 1'b1;
                    w_md_sel    = 1'b0;
                    w_x_stall   = 1'b1;
                    w_state_nxt = WAIT_TOP;
                end else if (bus.md_req_bot) begin
                    w_md_start  = 1'b1;
                    w_md_sel    = 1'b1;
                    w_x_stall   = 1'b1;
                    w_state_nxt = WAIT_BOT;
                end
            end
            WAIT_TOP: begin
                w_x_stall = 1'b1;
                w_md_sel  = 1'b0;
                if (bus.md_ready) begin
                    w_cap_top = 1'b1;
                    // Bot op is launched in the same cycle the top result lands
                    if (bus.md_req_bot) begin
                        w_md_start  = 1'b1;
                        w_md_sel    = 1'b1;
                        w_state_nxt = WAIT_BOT;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            WAIT_BOT: begin
                w_x_stall = 1'b1;
                w_md_sel  = 1'b1;
                if (bus.md_ready) begin
                    w_cap_bot   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            // The bundle that was just served leaves X now; its requests are stale
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Pipe-register control: x_stall outranks branch flush, which outranks load-use
    always_comb begin
        bus.fd_we    = 1'b1;
        bus.dx_we    = 1'b1;
        bus.dx_nop   = 1'b0;
        bus.xm_we    = 1'b1;
        bus.xm_nop   = 1'b0;
        bus.fd_flush = 1'b0;
        bus.dx_flush = 1'b0;
        if (w_x_stall) begin
            bus.fd_we  = 1'b0;
            bus.dx_we  = 1'b0;
            bus.xm_nop = 1'b1;
        end else if (bus.br_taken) begin
            bus.fd_flush = 1'b1;
            bus.dx_flush = 1'b1;
        end else if (bus.ld_use_hazard) begin
            bus.fd_we  = 1'b0;
            bus.dx_nop = 1'b1;
        end
    end

    assign w_in_wait   = (r_state == WAIT_TOP) || (r_state == WAIT_BOT);
    assign w_stall_evt = w_x_stall || (bus.ld_use_hazard && !bus.br_taken);

    // Scheduler state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Per-op wait counter with sticky timeout; counter parks at the limit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else if (w_md_start) begin
            r_wait_cnt <= '0;
        end else if (w_in_wait) begin
            if (r_wait_cnt != c_WAIT_MAX) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (r_wait_cnt >= c_WAIT_LAST) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Saturating count of stall cycles (X hold or load-use bubble)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall_evt && (r_stall_cnt != {STALL_CNT_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign bus.md_start     = w_md_start;
    assign bus.md_sel       = w_md_sel;
    assign bus.md_cap_top   = w_cap_top;
    assign bus.md_cap_bot   = w_cap_bot;
    assign bus.stall_cycles = r_stall_cnt;
    assign bus.md_timeout   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_x_stage_md_sched.sv
// ============================================================================
// Module      : tb_x_stage_md_sched
// Description : Self-checking bench for x_stage_md_sched. Two instances run in
//               lockstep: default parameters, and MD_MAX_CYCLES=4/STALL_CNT_W=3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_x_stage_md_sched;

    logic clk;
    logic reset;
    logic rt, rb, rd, ld, br;

    int n_checks = 0;
    int n_err    = 0;

    x_stage_md_sched_if #(.STALL_CNT_W(16)) ifa ();
    x_stage_md_sched_if #(.STALL_CNT_W(3))  ifb ();

    assign ifa.md_req_top = rt;  assign ifb.md_req_top = rt;
    assign ifa.md_req_bot = rb;  assign ifb.md_req_bot = rb;
    assign ifa.md_ready   = rd;  assign ifb.md_ready   = rd;
    assign ifa.ld_use_hazard = ld; assign ifb.ld_use_hazard = ld;
    assign ifa.br_taken   = br;  assign ifb.br_taken   = br;

    x_stage_md_sched #(.MD_MAX_CYCLES(40), .STALL_CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    x_stage_md_sched #(.MD_MAX_CYCLES(4), .STALL_CNT_W(3)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed control views {start, sel, cap_top, cap_bot, fd_we, dx_we, dx_nop, xm_we, xm_nop, fd_flush, dx_flush}
    logic [10:0] ctrl_a, ctrl_b;
    assign ctrl_a = {ifa.md_start, ifa.md_sel, ifa.md_cap_top, ifa.md_cap_bot, ifa.fd_we, ifa.dx_we,
                     ifa.dx_nop, ifa.xm_we, ifa.xm_nop, ifa.fd_flush, ifa.dx_flush};
    assign ctrl_b = {ifb.md_start, ifb.md_sel, ifb.md_cap_top, ifb.md_cap_bot, ifb.fd_we, ifb.dx_we,
                     ifb.dx_nop, ifb.xm_we, ifb.xm_nop, ifb.fd_flush, ifb.dx_flush};

    // ---------------- Reference model ----------------
    // serving: lane whose result is outstanding (-1 none, 0 top, 1 bot)
    int     m_serving;
    bit     m_leaving;     // bundle just completed, requests stale this cycle
    int     m_wait;        // cycles waited on current op
    longint m_stall;       // unbounded stall count
    bit     m_to_a, m_to_b;
    // expected combinational outputs for current cycle
    bit     e_start, e_sel, e_ct, e_cb, e_hold;
    logic [10:0] e_ctrl;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        m_serving = -1; m_leaving = 0; m_wait = 0; m_stall = 0; m_to_a = 0; m_to_b = 0;
    endtask

    task automatic model_comb();
        bit fdw, dxw, dxn, xmn, fl;
        e_start = 0; e_sel = 0; e_ct = 0; e_cb = 0; e_hold = 0;
        if (!m_leaving) begin
            if (m_serving < 0) begin
                if (rt || rb) begin
                    e_start = 1; e_sel = !rt; e_hold = 1;
                end
            end else begin
                e_hold = 1;
                e_sel  = (m_serving == 1);
                if (rd && m_serving == 0) begin
                    e_ct = 1;
                    if (rb) begin e_start = 1; e_sel = 1; end
                end
                if (rd && m_serving == 1) e_cb = 1;
            end
        end
        fdw = 1; dxw = 1; dxn = 0; xmn = 0; fl = 0;
        if (e_hold)  begin fdw = 0; dxw = 0; xmn = 1; end
        else if (br) fl = 1;
        else if (ld) begin fdw = 0; dxn = 1; end
        e_ctrl = {e_start, e_sel, e_ct, e_cb, fdw, dxw, dxn, 1'b1, xmn, fl, fl};
    endtask

    task automatic model_step();
        if (e_hold || (ld && !br)) m_stall++;
        if (m_leaving) begin
            m_leaving = 0;
        end else if (m_serving < 0) begin
            if (rt || rb) begin m_serving = rt ? 0 : 1; m_wait = 0; end
        end else if (e_start) begin
            m_serving = 1; m_wait = 0;
        end else begin
            m_wait++;
            if (m_wait >= 40) m_to_a = 1;
            if (m_wait >= 4)  m_to_b = 1;
            if (rd) begin m_serving = -1; m_leaving = 1; end
        end
    endtask

    // ---------------- Stimulus helpers ----------------
    task automatic drive(input bit t, input bit b, input bit r, input bit l, input bit j);
        @(negedge clk);
        rt = t; rb = b; rd = r; ld = l; br = j;
        #1;
        model_comb();
        chk("ctrl_a", 32'(ctrl_a), 32'(e_ctrl));
        chk("ctrl_b", 32'(ctrl_b), 32'(e_ctrl));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("stall_a", 32'(ifa.stall_cycles), (m_stall > 65535) ? 32'd65535 : 32'(m_stall));
        chk("stall_b", 32'(ifb.stall_cycles), (m_stall > 7) ? 32'd7 : 32'(m_stall));
        chk("timeout_a", 32'(ifa.md_timeout), 32'(m_to_a));
        chk("timeout_b", 32'(ifb.md_timeout), 32'(m_to_b));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        rt = 0; rb = 0; rd = 0; ld = 0; br = 0;
        #1;
        model_reset();
        chk("rst_stall_a", 32'(ifa.stall_cycles), 32'd0);
        chk("rst_stall_b", 32'(ifb.stall_cycles), 32'd0);
        chk("rst_timeout_a", 32'(ifa.md_timeout), 32'd0);
        chk("rst_timeout_b", 32'(ifb.md_timeout), 32'd0);
        chk("rst_ctrl_a", 32'(ctrl_a), 32'h068);
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [4:0]  in;    // {req_top, req_bot, ready, ld_use, br}
        logic [10:0] exp;
        int          inc;
    } vec_t;

    vec_t tbl [8];

    initial begin
        reset = 1'b0;
        rt = 0; rb = 0; rd = 0; ld = 0; br = 0;
        model_reset();

        tbl[0] = '{5'b00000, 11'b00001101000, 0};
        tbl[1] = '{5'b00010, 11'b00000111000, 1};
        tbl[2] = '{5'b00001, 11'b00001101011, 0};
        tbl[3] = '{5'b00011, 11'b00001101011, 0};
        tbl[4] = '{5'b00100, 11'b00001101000, 0};
        tbl[5] = '{5'b10000, 11'b10000001100, 1};
        tbl[6] = '{5'b01000, 11'b11000001100, 1};
        tbl[7] = '{5'b11111, 11'b10000001100, 1};

        repeat (2) @(posedge clk);

        // Single-cycle decode from IDLE
        for (int i = 0; i < 8; i++) begin
            do_reset();
            drive(tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
            chk($sformatf("vec%0d_ctrl", i), 32'(ctrl_a), 32'(tbl[i].exp));
            tick();
            chk($sformatf("vec%0d_stall", i), 32'(ifa.stall_cycles), 32'(tbl[i].inc));
        end

        // Top-only op, ready 5 cycles after start
        do_reset();
        drive(1, 0, 0, 0, 0);
        chk("top_start", 32'({ifa.md_start, ifa.md_sel}), 32'b10);
        tick();
        for (int k = 1; k < 5; k++) begin
            drive(1, 0, 0, 0, 0);
            chk("top_wait_nop", 32'(ifa.xm_nop), 32'd1);
            tick();
        end
        drive(1, 0, 1, 0, 0);
        chk("top_cap", 32'({ifa.md_cap_top, ifa.xm_nop, ifa.md_start}), 32'b110);
        tick();
        drive(1, 0, 0, 0, 0);
        chk("top_done", 32'({ifa.xm_nop, ifa.md_start, ifa.fd_we}), 32'b001);
        tick();
        chk("top_stall6", 32'(ifa.stall_cycles), 32'd6);
        drive(0, 0, 0, 0, 0); tick();

        // Top+bot ops
        do_reset();
        drive(1, 1, 0, 0, 0);
        chk("tb_start_top", 32'({ifa.md_start, ifa.md_sel}), 32'b10);
        tick();
        repeat (2) begin drive(1, 1, 0, 0, 0); tick(); end
        drive(1, 1, 1, 0, 0);
        chk("tb_cap_top_start_bot", 32'({ifa.md_cap_top, ifa.md_start, ifa.md_sel}), 32'b111);
        tick();
        repeat (2) begin drive(1, 1, 0, 0, 0); tick(); end
        drive(1, 1, 1, 0, 0);
        chk("tb_cap_bot", 32'({ifa.md_cap_bot, ifa.md_sel, ifa.md_start}), 32'b110);
        tick();
        drive(1, 1, 0, 0, 0);
        chk("tb_done", 32'({ifa.md_start, ifa.xm_nop}), 32'b00);
        tick();
        drive(0, 0, 0, 0, 0); tick();

        // Load-use alone, then with branch
        do_reset();
        drive(0, 0, 0, 1, 0);
        chk("ld_ctrl", 32'({ifa.fd_we, ifa.dx_we, ifa.dx_nop}), 32'b011);
        tick();
        chk("ld_stall1", 32'(ifa.stall_cycles), 32'd1);
        drive(0, 0, 0, 1, 1);
        chk("ldbr_flush", 32'({ifa.fd_flush, ifa.dx_flush, ifa.fd_we, ifa.dx_nop}), 32'b1110);
        tick();
        chk("ldbr_stall", 32'(ifa.stall_cycles), 32'd1);

        // Branch held through an X stall
        do_reset();
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 1);
        chk("br_in_wait", 32'({ifa.fd_flush, ifa.dx_flush}), 32'b00);
        tick();
        drive(0, 0, 1, 0, 1);
        chk("br_at_ready", 32'({ifa.md_cap_top, ifa.fd_flush}), 32'b10);
        tick();
        drive(0, 0, 0, 0, 1);
        chk("br_after_stall", 32'({ifa.fd_flush, ifa.dx_flush}), 32'b11);
        tick();

        // Timeout on the MD_MAX_CYCLES=4 instance, then reset mid-wait
        do_reset();
        drive(1, 0, 0, 0, 0); tick();
        for (int k = 1; k <= 4; k++) begin
            drive(1, 0, 0, 0, 0); tick();
            if (k == 3) chk("to_b_before", 32'(ifb.md_timeout), 32'd0);
        end
        chk("to_b_set", 32'(ifb.md_timeout), 32'd1);
        chk("to_a_clear", 32'(ifa.md_timeout), 32'd0);
        do_reset();
        drive(0, 0, 1, 0, 0);
        chk("post_rst_idle", 32'(ctrl_b), 32'h068);
        tick();

        // Stall counter saturation on the 3-bit instance
        do_reset();
        repeat (10) begin drive(0, 0, 0, 1, 0); tick(); end
        chk("sat_b", 32'(ifb.stall_cycles), 32'd7);
        chk("sat_a", 32'(ifa.stall_cycles), 32'd10);

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 79) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 5) == 0);
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
